hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
Next-generation pipeline hazard controller for the 5-stage core. It replaces fixed one-cycle load-use detection with a pending-write scoreboard, which supports variable-latency loads and multi-cycle ops (mul/div). It also adds a data-memory busy freeze, an outstanding-op limit and a stall performance counter. It sits beside the decode stage and drives the IF/ID and ID/EX pipeline-register controls and the EX forwarding muxes.

Parameters:
NREGS, 32, architectural register count; x0 is never tracked.
RWIDTH, $clog2(NREGS), register index width.
MAX_OUTSTANDING, 4, maximum in-flight long-latency ops (1..NREGS-1).
CNT_W, $clog2(MAX_OUTSTANDING+1), width of the outstanding counter.
PERF_W, 32, stall performance counter width.

Ports:
clk  in  1  core clock; one clock domain.
reset  in  1  synchronous, active-high reset.
d_valid  in  1  ID holds a real instruction.
d_rs1, d_rs2  in  RWIDTH  ID source registers.
d_uses_rs1, d_uses_rs2  in  1  ID instruction actually reads rs1/rs2.
d_rd  in  RWIDTH  ID destination register.
d_regwren  in  1  ID instruction writes rd.
d_long  in  1  ID instruction is long-latency (load, mul, div).
e_rs1, e_rs2  in  RWIDTH  EX source registers.
m_rd, w_rd  in  RWIDTH  MEM/WB destination registers.
m_regwren, w_regwren  in  1  MEM/WB write enables (short ops only).
lc_valid  in  1  long-latency completion; RF written this cycle.
lc_rd  in  RWIDTH  completing destination register.
e_redirect  in  1  taken branch or JAL/JALR resolved in EX.
mem_busy  in  1  data memory not ready; whole pipeline must freeze.
stall_if  out  1  hold PC.
ifid_wren  out  1  IF/ID register update enable.
ifid_flush  out  1  IF/ID becomes NOP.
idex_flush  out  1  ID/EX becomes bubble.
pipe_hold  out  1  freeze EX/MEM/WB registers.
rs1_sel, rs2_sel  out  2  forwarding select: 00 none, 01 MEM, 10 WB, 11 reserved (never driven).
pending_cnt  out  CNT_W  outstanding long-latency ops.
sb_err  out  1  sticky: a completion arrived for a register that was not pending.
stall_cycles  out  PERF_W  saturating count of ID stall cycles.

Behaviour:
- Reset (sync): scoreboard all 0, pending_cnt=0, sb_err=0, stall_cycles=0. Combinational outputs follow the rules below. Outstanding ops are discarded on reset mid-operation.
- Completion clear mask: clr = lc_valid && lc_rd!=0 && sb[lc_rd]. The effective view for hazard checks is sb_eff = sb with bit lc_rd cleared when clr (same-cycle bypass, because the RF write-before-read covers it).
- raw = d_uses_rs1&&rs1!=0&&sb_eff[rs1] || d_uses_rs2&&rs2!=0&&sb_eff[rs2].
- waw = d_regwren&&d_rd!=0&&sb_eff[d_rd].
- full = d_long && (pending_cnt - clr) == MAX_OUTSTANDING.
- stall_d = d_valid && (raw||waw||full).
- Priority (highest first):
  1. mem_busy: stall_if=1, ifid_wren=0, ifid_flush=0, idex_flush=0, pipe_hold=1. e_redirect is held by the frozen EX stage, so it takes effect on the first cycle after mem_busy drops.
  2. e_redirect: stall_if=0, ifid_wren=1, ifid_flush=1, idex_flush=1. This overrides stall_d.
  3. stall_d: stall_if=1, ifid_wren=0, idex_flush=1.
  4. Otherwise all controls are 0, except ifid_wren=1.
- Issue: issue = d_valid && !mem_busy && !e_redirect && !stall_d.
  - If issue && d_long && d_regwren && d_rd!=0, set sb[d_rd] at the clock edge.
- Counter update: pending_cnt += set - clr.
  - A set and a clr on the same rd in the same cycle leaves the bit at 1 and the count unchanged.
  - The count never exceeds MAX_OUTSTANDING and never underflows.
- lc_valid with lc_rd!=0 and sb[lc_rd]==0: no state change, sb_err<=1 (sticky until reset). lc_rd==0 is ignored silently.
- stall_cycles increments when stall_d && !e_redirect && !mem_busy, and saturates at all-ones.
- Forwarding (combinational, per source): MEM match (m_regwren, m_rd!=0, m_rd==e_rsX) gives 01; else WB match gives 10; else 00. A long-op consumer can never reach EX with a pending source, so no completion-bypass select exists.

Decomposition:
- Package hazard_pkg: fwd_sel_e enum (FWD_NONE=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10), and reuse of the OPCODE_* constants for upstream d_long decode.
- Sub-module pending_scoreboard: NREGS bit vector, set/clear ports, pending_cnt, sb_err, and the sb_eff output. The top level keeps the priority logic, forwarding and the perf counter.

Test Plan:
- Issue load x5 (d_long); next ID reads x5 → stall_if=1, idex_flush=1 each cycle until lc_valid, lc_rd=5. In the completion cycle the stall drops (bypass); pending_cnt goes 1→0.
- Issue 4 long ops to x1..x4, then a 5th long op to x6 → full stall. A completion of x2 in the same cycle lets the 5th op issue; pending_cnt stays 4.
- stall_d active and e_redirect=1 → ifid_flush=1, idex_flush=1, stall_if=0, stall_cycles unchanged.
- mem_busy=1 for 3 cycles with e_redirect=1 → pipe_hold=1, no flush. Flush asserts in the cycle mem_busy drops.
- m_rd=w_rd=e_rs1=7, both wren → rs1_sel=01. Then m_regwren=0 → 10. With e_rs1=0 → 00.
- lc_valid, lc_rd=9 with x9 not pending → sb_err=1 and stays 1. reset → sb_err=0, pending_cnt=0, scoreboard clear.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the pipeline hazard controller.
package hazard_pkg;
  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_MEM  = 2'b01,
    FWD_WB   = 2'b10
  } fwd_sel_e;
  // Upstream decode uses these to derive d_long (loads, mul/div in OP).
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
endpackage

// File: rtl/pending_scoreboard.sv
// pending_scoreboard: per-register pending-write bits, outstanding count and sticky error.
module pending_scoreboard #(
  parameter int NREGS = 32,
  parameter int RWIDTH = $clog2(NREGS),
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              set_i,
  input  logic [RWIDTH-1:0] set_rd_i,
  input  logic              lc_valid_i,
  input  logic [RWIDTH-1:0] lc_rd_i,
  output logic [NREGS-1:0]  sb_eff_o,
  output logic              clr_o,
  output logic [CNT_W-1:0]  pending_cnt_o,
  output logic              sb_err_o
);
  logic [NREGS-1:0] sb_q, sb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic err_q, err_d, hit, set_v;
  // A set and a clear on the same register cancel: the bit stays 1 and the count holds.
  always_comb begin
    hit = sb_q[lc_rd_i];
    set_v = set_i && set_rd_i != '0;
    clr_o = lc_valid_i && lc_rd_i != '0 && hit;
    sb_eff_o = sb_q & ~(NREGS'(clr_o) << lc_rd_i);
    sb_d = sb_eff_o | (NREGS'(set_v) << set_rd_i);
    cnt_d = cnt_q + CNT_W'(set_v) - CNT_W'(clr_o);
    err_d = err_q || (lc_valid_i && lc_rd_i != '0 && !hit);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sb_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      sb_q <= sb_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign pending_cnt_o = cnt_q;
  assign sb_err_o = err_q;
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: scoreboard-based stall/flush control, EX forwarding and stall counter.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int RWIDTH = $clog2(NREGS),
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W = $clog2(MAX_OUTSTANDING + 1),
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              d_valid,
  input  logic [RWIDTH-1:0] d_rs1,
  input  logic [RWIDTH-1:0] d_rs2,
  input  logic              d_uses_rs1,
  input  logic              d_uses_rs2,
  input  logic [RWIDTH-1:0] d_rd,
  input  logic              d_regwren,
  input  logic              d_long,
  input  logic [RWIDTH-1:0] e_rs1,
  input  logic [RWIDTH-1:0] e_rs2,
  input  logic [RWIDTH-1:0] m_rd,
  input  logic [RWIDTH-1:0] w_rd,
  input  logic              m_regwren,
  input  logic              w_regwren,
  input  logic              lc_valid,
  input  logic [RWIDTH-1:0] lc_rd,
  input  logic              e_redirect,
  input  logic              mem_busy,
  output logic              stall_if,
  output logic              ifid_wren,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              pipe_hold,
  output logic [1:0]        rs1_sel,
  output logic [1:0]        rs2_sel,
  output logic [CNT_W-1:0]  pending_cnt,
  output logic              sb_err,
  output logic [PERF_W-1:0] stall_cycles
);
  logic [NREGS-1:0] sb_eff;
  logic [PERF_W-1:0] perf_q, perf_d;
  logic clr, raw, waw, full, stall_d, issue;
  fwd_sel_e fwd1, fwd2;
  pending_scoreboard #(.NREGS(NREGS), .RWIDTH(RWIDTH), .MAX_OUTSTANDING(MAX_OUTSTANDING), .CNT_W(CNT_W)) u_sb (
    .clk(clk), .reset(reset),
    .set_i(issue && d_long && d_regwren), .set_rd_i(d_rd),
    .lc_valid_i(lc_valid), .lc_rd_i(lc_rd),
    .sb_eff_o(sb_eff), .clr_o(clr), .pending_cnt_o(pending_cnt), .sb_err_o(sb_err)
  );
  always_comb begin
    raw = (d_uses_rs1 && d_rs1 != '0 && sb_eff[d_rs1]) || (d_uses_rs2 && d_rs2 != '0 && sb_eff[d_rs2]);
    waw = d_regwren && d_rd != '0 && sb_eff[d_rd];
    full = d_long && (pending_cnt - CNT_W'(clr)) == CNT_W'(MAX_OUTSTANDING);
    stall_d = d_valid && (raw || waw || full);
    issue = d_valid && !mem_busy && !e_redirect && !stall_d;
    // mem_busy freezes everything, a redirect beats a decode stall.
    stall_if = mem_busy || (!e_redirect && stall_d);
    ifid_wren = !mem_busy && (e_redirect || !stall_d);
    ifid_flush = !mem_busy && e_redirect;
    idex_flush = !mem_busy && (e_redirect || stall_d);
    pipe_hold = mem_busy;
    fwd1 = (m_regwren && m_rd != '0 && m_rd == e_rs1) ? FWD_MEM :
           (w_regwren && w_rd != '0 && w_rd == e_rs1) ? FWD_WB : FWD_NONE;
    fwd2 = (m_regwren && m_rd != '0 && m_rd == e_rs2) ? FWD_MEM :
           (w_regwren && w_rd != '0 && w_rd == e_rs2) ? FWD_WB : FWD_NONE;
    rs1_sel = fwd1;
    rs2_sel = fwd2;
    perf_d = (stall_d && !e_redirect && !mem_busy && perf_q != '1) ? perf_q + PERF_W'(1) : perf_q;
  end
  always_ff @(posedge clk) begin
    if (reset) perf_q <= '0;
    else perf_q <= perf_d;
  end
  assign stall_cycles = perf_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed + random stimulus, expected outputs queued from a reference model.
module tb_hazard_scoreboard;
  typedef struct {
    logic dv, u1, u2, wr, lng, mw, ww, lcv, red, mb, rst;
    logic [4:0] rs1, rs2, rd, ers1, ers2, mrd, wrd, lcrd;
  } stim_t;
  typedef struct {
    int stall_if, ifid_wren, ifid_flush, idex_flush, pipe_hold, rs1_sel, rs2_sel, cnt, err;
    longint stalls;
  } exp_t;

  logic clk = 0, reset = 1;
  logic d_valid = 0, d_uses_rs1 = 0, d_uses_rs2 = 0, d_regwren = 0, d_long = 0;
  logic m_regwren = 0, w_regwren = 0, lc_valid = 0, e_redirect = 0, mem_busy = 0;
  logic [4:0] d_rs1 = 0, d_rs2 = 0, d_rd = 0, e_rs1 = 0, e_rs2 = 0, m_rd = 0, w_rd = 0, lc_rd = 0;
  logic stall_if, ifid_wren, ifid_flush, idex_flush, pipe_hold, sb_err;
  logic [1:0] rs1_sel, rs2_sel;
  logic [2:0] pending_cnt;
  logic [31:0] stall_cycles;

  hazard_scoreboard dut (
    .clk(clk), .reset(reset), .d_valid(d_valid), .d_rs1(d_rs1), .d_rs2(d_rs2),
    .d_uses_rs1(d_uses_rs1), .d_uses_rs2(d_uses_rs2), .d_rd(d_rd), .d_regwren(d_regwren),
    .d_long(d_long), .e_rs1(e_rs1), .e_rs2(e_rs2), .m_rd(m_rd), .w_rd(w_rd),
    .m_regwren(m_regwren), .w_regwren(w_regwren), .lc_valid(lc_valid), .lc_rd(lc_rd),
    .e_redirect(e_redirect), .mem_busy(mem_busy), .stall_if(stall_if), .ifid_wren(ifid_wren),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .pipe_hold(pipe_hold), .rs1_sel(rs1_sel),
    .rs2_sel(rs2_sel), .pending_cnt(pending_cnt), .sb_err(sb_err), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int errors = 0, checks = 0;
  bit pend[32];
  bit m_err;
  longint m_stalls;

  task automatic chk(input string n, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", n, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk("stall_if", longint'(stall_if), e.stall_if);
      chk("ifid_wren", longint'(ifid_wren), e.ifid_wren);
      chk("ifid_flush", longint'(ifid_flush), e.ifid_flush);
      chk("idex_flush", longint'(idex_flush), e.idex_flush);
      chk("pipe_hold", longint'(pipe_hold), e.pipe_hold);
      chk("rs1_sel", longint'(rs1_sel), e.rs1_sel);
      chk("rs2_sel", longint'(rs2_sel), e.rs2_sel);
      chk("pending_cnt", longint'(pending_cnt), e.cnt);
      chk("sb_err", longint'(sb_err), e.err);
      chk("stall_cycles", longint'(stall_cycles), e.stalls);
    end
  end

  function automatic int fwd(logic mw, logic [4:0] mrd, logic ww, logic [4:0] wrd, logic [4:0] rs);
    if (mw && mrd != 0 && mrd == rs) return 1;
    if (ww && wrd != 0 && wrd == rs) return 2;
    return 0;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  // Drive one cycle, queue the expected outputs, then advance the model across the edge.
  task automatic step(input stim_t s);
    exp_t e;
    bit eff[32];
    bit clr, raw, waw, full, stall, issue;
    int cnt;
    @(posedge clk);
    #1;
    d_valid = s.dv; d_rs1 = s.rs1; d_rs2 = s.rs2; d_uses_rs1 = s.u1; d_uses_rs2 = s.u2;
    d_rd = s.rd; d_regwren = s.wr; d_long = s.lng; e_rs1 = s.ers1; e_rs2 = s.ers2;
    m_rd = s.mrd; w_rd = s.wrd; m_regwren = s.mw; w_regwren = s.ww; lc_valid = s.lcv;
    lc_rd = s.lcrd; e_redirect = s.red; mem_busy = s.mb; reset = s.rst;
    cnt = 0;
    foreach (pend[i]) cnt += int'(pend[i]);
    clr = s.lcv && s.lcrd != 0 && pend[s.lcrd];
    eff = pend;
    if (clr) eff[s.lcrd] = 0;
    raw = (s.u1 && s.rs1 != 0 && eff[s.rs1]) || (s.u2 && s.rs2 != 0 && eff[s.rs2]);
    waw = s.wr && s.rd != 0 && eff[s.rd];
    full = s.lng && (cnt - int'(clr)) == 4;
    stall = s.dv && (raw || waw || full);
    issue = s.dv && !s.mb && !s.red && !stall;
    if (s.mb) e = '{1, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    else if (s.red) e = '{0, 1, 1, 1, 0, 0, 0, 0, 0, 0};
    else if (stall) e = '{1, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    else e = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    e.rs1_sel = fwd(s.mw, s.mrd, s.ww, s.wrd, s.ers1);
    e.rs2_sel = fwd(s.mw, s.mrd, s.ww, s.wrd, s.ers2);
    e.cnt = cnt;
    e.err = int'(m_err);
    e.stalls = m_stalls;
    q.push_back(e);
    if (s.rst) begin
      pend = '{default: 0};
      m_err = 0;
      m_stalls = 0;
    end else begin
      if (s.lcv && s.lcrd != 0 && !pend[s.lcrd]) m_err = 1;
      if (clr) pend[s.lcrd] = 0;
      if (issue && s.lng && s.wr && s.rd != 0) pend[s.rd] = 1;
      if (stall && !s.red && !s.mb && m_stalls != 64'hFFFF_FFFF) m_stalls++;
    end
  endtask

  task automatic long_op(input logic [4:0] rd);
    stim_t s;
    s = idle();
    s.dv = 1; s.lng = 1; s.wr = 1; s.rd = rd;
    step(s);
  endtask

  task automatic complete(input logic [4:0] rd);
    stim_t s;
    s = idle();
    s.lcv = 1; s.lcrd = rd;
    step(s);
  endtask

  initial begin
    stim_t s;
    int pl[$];
    pend = '{default: 0};
    m_err = 0;
    m_stalls = 0;
    repeat (2) @(posedge clk);
    step(idle());
    // load-use on x5 until completion bypass
    long_op(5);
    s = idle();
    s.dv = 1; s.u1 = 1; s.rs1 = 5; s.rd = 6; s.wr = 1;
    repeat (3) step(s);
    s.lcv = 1; s.lcrd = 5;
    step(s);
    step(idle());
    // fill to the outstanding limit, then a same-cycle completion frees a slot
    for (int r = 1; r <= 4; r++) long_op(5'(r));
    long_op(6);
    s = idle();
    s.dv = 1; s.lng = 1; s.wr = 1; s.rd = 6; s.lcv = 1; s.lcrd = 2;
    step(s);
    complete(1); complete(3); complete(4); complete(6);
    // redirect overrides a decode stall
    long_op(8);
    s = idle();
    s.dv = 1; s.u2 = 1; s.rs2 = 8; s.red = 1;
    step(s);
    complete(8);
    // mem_busy freezes a pending redirect
    s = idle();
    s.red = 1; s.mb = 1;
    repeat (3) step(s);
    s.mb = 0;
    step(s);
    // forwarding priority
    s = idle();
    s.ers1 = 7; s.mrd = 7; s.wrd = 7; s.mw = 1; s.ww = 1; s.ers2 = 7;
    step(s);
    s.mw = 0;
    step(s);
    s.ers1 = 0;
    step(s);
    // spurious completion sets sticky error, reset clears it
    long_op(10);
    complete(9);
    repeat (2) step(idle());
    s = idle();
    s.rst = 1;
    step(s);
    step(idle());
    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      s = idle();
      s.dv = $urandom_range(0, 99) < 80;
      s.rs1 = 5'($urandom_range(0, 7)); s.rs2 = 5'($urandom_range(0, 7));
      s.u1 = 1'($urandom); s.u2 = 1'($urandom);
      s.rd = 5'($urandom_range(0, 9)); s.wr = $urandom_range(0, 99) < 70;
      s.lng = $urandom_range(0, 99) < 35;
      s.ers1 = 5'($urandom_range(0, 3)); s.ers2 = 5'($urandom_range(0, 3));
      s.mrd = 5'($urandom_range(0, 3)); s.wrd = 5'($urandom_range(0, 3));
      s.mw = 1'($urandom); s.ww = 1'($urandom);
      s.red = $urandom_range(0, 99) < 8;
      s.mb = $urandom_range(0, 99) < 10;
      s.rst = $urandom_range(0, 999) < 5;
      pl.delete();
      foreach (pend[i]) if (pend[i]) pl.push_back(i);
      s.lcv = $urandom_range(0, 99) < 30;
      if (pl.size() != 0 && $urandom_range(0, 99) < 95) s.lcrd = 5'(pl[$urandom_range(0, pl.size() - 1)]);
      else s.lcrd = 5'($urandom_range(0, 12));
      step(s);
    end
    for (int w = 0; w < 10 && q.size() != 0; w++) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
